// File: rtl/i2c_slave.sv
// I2C target on the RIB bus: answers one 7-bit address, ACKs every written byte,
// serves reads from a 16-bit transmit register and flags bus events on int_sig_o.

module i2c_slave #(
    parameter logic [6:0] OWN_ADDR_RST = 7'h48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        int_sig_o,
    input  logic        scl,
    inout  wire         sda
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    state_t      state;
    logic [2:0]  scl_sync;   // [1] is the synchronized level, [2] its history
    logic [2:0]  sda_sync;
    logic [7:0]  shift;
    logic [7:0]  tx_shift;
    logic [3:0]  bit_cnt;
    logic        ack_armed;
    logic        rw;
    logic        byte_idx;
    logic        sda_oe;
    logic [6:0]  own_addr;
    logic [15:0] tx_data;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        tx_done;
    logic        addr_seen;

    logic        scl_rise, scl_fall, sda_rise, sda_fall;
    logic        start_cond, stop_cond;
    logic        busy;
    logic [3:0]  sel;
    logic [7:0]  shift_next;
    logic [7:0]  tx_byte;
    logic        unused_bits;

    assign scl_rise   = scl_sync[1] & ~scl_sync[2];
    assign scl_fall   = ~scl_sync[1] & scl_sync[2];
    assign sda_rise   = sda_sync[1] & ~sda_sync[2];
    assign sda_fall   = ~sda_sync[1] & sda_sync[2];
    assign start_cond = sda_fall & scl_sync[1];
    assign stop_cond  = sda_rise & scl_sync[1];
    assign busy       = (state != IDLE);
    assign sel        = addr_i[19:16];
    assign shift_next = {shift[6:0], sda_sync[1]};
    assign tx_byte    = byte_idx ? tx_data[7:0] : tx_data[15:8];
    assign unused_bits = ^{addr_i[31:20], addr_i[15:0], data_i[31:16]};

    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_comb begin
        // NOTE: default first, so no decode path leaves data_o unassigned and infers a latch.
        data_o = '0;
        case (sel)
            4'd1:    data_o[6:0]  = own_addr;
            4'd2:    data_o[15:0] = tx_data;
            4'd3:    data_o[15:0] = rx_data;
            4'd4:    data_o[3:0]  = {addr_seen, tx_done, rx_valid, busy};
            default: ;
        endcase
    end

    // NOTE: non-blocking only; every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            scl_sync  <= '1;
            sda_sync  <= '1;
            shift     <= '0;
            tx_shift  <= '0;
            bit_cnt   <= '0;
            ack_armed <= 1'b0;
            rw        <= 1'b0;
            byte_idx  <= 1'b0;
            sda_oe    <= 1'b0;
            own_addr  <= OWN_ADDR_RST;
            tx_data   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_done   <= 1'b0;
            addr_seen <= 1'b0;
            int_sig_o <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[1:0], scl};
            sda_sync  <= {sda_sync[1:0], sda};
            int_sig_o <= rx_valid | tx_done;

            if (we_i) begin
                case (sel)
                    4'd1: own_addr <= data_i[6:0];
                    4'd2: tx_data  <= data_i[15:0];
                    4'd4: begin
                        if (data_i[1]) rx_valid  <= 1'b0;
                        if (data_i[2]) tx_done   <= 1'b0;
                        if (data_i[3]) addr_seen <= 1'b0;
                    end
                    default: ;
                endcase
            end

            // NOTE: the FSM's flag sets come after the W1C clears above, so a same-cycle set wins.
            if (start_cond) begin
                state    <= ADDR;
                bit_cnt  <= '0;
                byte_idx <= 1'b0;
                sda_oe   <= 1'b0;
            end else if (stop_cond) begin
                state   <= IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shift <= shift_next;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            if (shift_next[7:1] == own_addr) begin
                                addr_seen <= 1'b1;
                                rw        <= shift_next[0];
                                ack_armed <= 1'b0;
                                state     <= ADDR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        if (!ack_armed) begin
                            sda_oe    <= 1'b1;
                            ack_armed <= 1'b1;
                        end else if (rw) begin
                            sda_oe   <= ~tx_byte[7];
                            tx_shift <= {tx_byte[6:0], 1'b0};
                            bit_cnt  <= 4'd1;
                            state    <= TX_BYTE;
                        end else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= RX_BYTE;
                        end
                    end
                    RX_BYTE: if (scl_rise) begin
                        shift <= shift_next;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt   <= '0;
                            rx_data   <= {rx_data[7:0], shift_next};
                            rx_valid  <= 1'b1;
                            ack_armed <= 1'b0;
                            state     <= RX_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    RX_ACK: if (scl_fall) begin
                        if (!ack_armed) begin
                            sda_oe    <= 1'b1;
                            ack_armed <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= RX_BYTE;
                        end
                    end
                    TX_BYTE: if (scl_fall) begin
                        // bit_cnt 0 means a new byte is sampled from tx_data on this fall
                        if (bit_cnt == 4'd0) begin
                            sda_oe   <= ~tx_byte[7];
                            tx_shift <= {tx_byte[6:0], 1'b0};
                            bit_cnt  <= 4'd1;
                        end else if (bit_cnt == 4'd8) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= TX_ACK;
                        end else begin
                            sda_oe   <= ~tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end
                    TX_ACK: if (scl_rise) begin
                        if (!sda_sync[1]) begin
                            byte_idx <= ~byte_idx;
                            bit_cnt  <= '0;
                            state    <= TX_BYTE;
                        end else begin
                            tx_done <= 1'b1;
                            state   <= WAIT_STOP;
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule
